// File: rtl/ofs_fim_eth_sb_tx_arb.sv
// Sideband TX arbiter. Each requester has a one-entry holding register. A round-robin
// grant merges the held words onto one registered output. Overwritten words are counted.

module ofs_fim_eth_sb_tx_arb_lane #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [DW-1:0] req_data,
  input  logic          grant,
  input  logic          ovf_clr,
  output logic          pend_vld,
  output logic [DW-1:0] pend_data,
  output logic          ovf_sticky,
  output logic          ovw
);
  // A new word loses the held word only when the held word is not leaving this cycle.
  assign ovw = req_valid & pend_vld & ~grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld   <= 1'b0;
      pend_data  <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (req_valid) begin
        pend_vld  <= 1'b1;
        pend_data <= req_data;
      end else if (grant) begin
        pend_vld  <= 1'b0;
      end
      if (ovw)          ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  end
endmodule

module ofs_fim_eth_sb_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 32,
  parameter int CW      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DW-1:0]      req_data,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic [NUM_REQ-1:0]         ovf_sticky,
  input  logic [NUM_REQ-1:0]         ovf_clr,
  output logic [CW-1:0]              drop_cnt
);
  localparam int SW = $clog2(NUM_REQ);
  localparam int PW = $clog2(NUM_REQ + 1);
  localparam int AW = CW + PW;

  logic [NUM_REQ-1:0]          pend_vld;
  logic [NUM_REQ-1:0][DW-1:0]  pend_data;
  logic [NUM_REQ-1:0]          ovw;
  logic [NUM_REQ-1:0]          gnt;
  logic [SW-1:0]               last_grant;
  logic [SW-1:0]               gnt_idx;
  logic [SW-1:0]               sidx;
  logic                        any_gnt;
  logic [PW-1:0]               pc;
  logic [AW-1:0]               drop_sum;
  logic [CW-1:0]               drop_nxt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    ofs_fim_eth_sb_tx_arb_lane #(.DW(DW)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[i]),
      .req_data  (req_data[i*DW +: DW]),
      .grant     (gnt[i]),
      .ovf_clr   (ovf_clr[i]),
      .pend_vld  (pend_vld[i]),
      .pend_data (pend_data[i]),
      .ovf_sticky(ovf_sticky[i]),
      .ovw       (ovw[i])
    );
  end

  // Round-robin search; k=NUM_REQ wraps back to last_grant so it is considered last.
  always_comb begin
    any_gnt = 1'b0;
    gnt_idx = '0;
    sidx    = '0;
    gnt     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sidx = SW'((int'(last_grant) + k) % NUM_REQ);
      if (!any_gnt && pend_vld[sidx]) begin
        any_gnt = 1'b1;
        gnt_idx = sidx;
      end
    end
    if (any_gnt) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_REQ; i++) pc = pc + PW'(ovw[i]);
    drop_sum = AW'(drop_cnt) + AW'(pc);
    drop_nxt = (|drop_sum[AW-1:CW]) ? '1 : drop_sum[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= SW'(NUM_REQ - 1);
      drop_cnt   <= '0;
    end else begin
      out_valid <= any_gnt;
      drop_cnt  <= drop_nxt;
      if (any_gnt) begin
        out_data   <= pend_data[gnt_idx];
        out_src    <= gnt_idx;
        last_grant <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_ofs_fim_eth_sb_tx_arb.sv
// Directed bench for ofs_fim_eth_sb_tx_arb: 4 requesters, 32-bit data, 4-bit drop counter.

module tb_ofs_fim_eth_sb_tx_arb;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NR-1:0]      req_valid = '0;
  logic [NR*DW-1:0]   req_data = '0;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [1:0]         out_src;
  logic [NR-1:0]      ovf_sticky;
  logic [NR-1:0]      ovf_clr = '0;
  logic [CW-1:0]      drop_cnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ofs_fim_eth_sb_tx_arb #(.NUM_REQ(NR), .DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .ovf_sticky(ovf_sticky),
    .ovf_clr   (ovf_clr),
    .drop_cnt  (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    ovf_clr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b exp 0", out_valid); end
    n_run++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", out_data); end
    n_run++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d exp 0", out_src); end
    n_run++; if (ovf_sticky !== 4'b0) begin n_fail++; $display("FAIL reset_ovf: got %b exp 0000", ovf_sticky); end
    n_run++; if (drop_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_drop: got %0d exp 0", drop_cnt); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 32'hA5A5_0002;
    tick();
    req_valid = '0;
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_c1_valid: got %0b exp 0", out_valid); end
    tick();
    n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_c2_valid: got %0b exp 1", out_valid); end
    n_run++; if (out_data !== 32'hA5A5_0002) begin n_fail++; $display("FAIL single_data: got %h exp a5a50002", out_data); end
    n_run++; if (out_src !== 2'd2) begin n_fail++; $display("FAIL single_src: got %0d exp 2", out_src); end
    tick();
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_c3_valid: got %0b exp 0", out_valid); end
    n_run++; if (out_data !== 32'hA5A5_0002) begin n_fail++; $display("FAIL single_hold_data: got %h exp a5a50002", out_data); end
    n_run++; if (drop_cnt !== 4'd0) begin n_fail++; $display("FAIL single_drop: got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h1111_0000 + 32'(i);
    tick();
    req_valid = '0;
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_c1_valid: got %0b exp 0", out_valid); end
    for (int i = 0; i < NR; i++) begin
      tick();
      n_run++; if (out_valid !== 1'b1 || out_src !== 2'(i) || out_data !== 32'h1111_0000 + 32'(i)) begin
        n_fail++; $display("FAIL rr_seq%0d: got v=%0b src=%0d data=%h exp v=1 src=%0d data=%h",
                           i, out_valid, out_src, out_data, i, 32'h1111_0000 + 32'(i));
      end
    end
    tick();
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_end_valid: got %0b exp 0", out_valid); end
  endtask

  task automatic test_overwrite();
    logic        ev [8];
    logic [1:0]  es [8];
    logic [31:0] ed [8];
    ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    es = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    ed = '{32'h0, 32'hA000_0000, 32'hB000_0001, 32'hA000_0002,
           32'hB000_0003, 32'hA000_0004, 32'hB000_0004, 32'h0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 5) ? 4'b0011 : 4'b0000;
      req_data[0*DW +: DW] = 32'hA000_0000 + 32'(c);
      req_data[1*DW +: DW] = 32'hB000_0000 + 32'(c);
      tick();
      n_run++; if (out_valid !== ev[c]) begin
        n_fail++; $display("FAIL ovw_valid_c%0d: got %0b exp %0b", c, out_valid, ev[c]);
      end
      if (ev[c]) begin
        n_run++; if (out_src !== es[c] || out_data !== ed[c]) begin
          n_fail++; $display("FAIL ovw_word_c%0d: got src=%0d data=%h exp src=%0d data=%h",
                             c, out_src, out_data, es[c], ed[c]);
        end
      end
    end
    n_run++; if (ovf_sticky !== 4'b0011) begin n_fail++; $display("FAIL ovw_sticky: got %b exp 0011", ovf_sticky); end
    n_run++; if (drop_cnt !== 4'd4) begin n_fail++; $display("FAIL ovw_drop: got %0d exp 4", drop_cnt); end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 6) ? 4'b1000 : 4'b0000;
      req_data[3*DW +: DW] = 32'h3000_0000 + 32'(c);
      tick();
      exp_v = (c >= 1 && c <= 6);
      n_run++; if (out_valid !== exp_v) begin
        n_fail++; $display("FAIL b2b_valid_c%0d: got %0b exp %0b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        n_run++; if (out_src !== 2'd3 || out_data !== 32'h3000_0000 + 32'(c - 1)) begin
          n_fail++; $display("FAIL b2b_word_c%0d: got src=%0d data=%h exp src=3 data=%h",
                             c, out_src, out_data, 32'h3000_0000 + 32'(c - 1));
        end
      end
    end
    n_run++; if (drop_cnt !== 4'd0) begin n_fail++; $display("FAIL b2b_drop: got %0d exp 0", drop_cnt); end
    n_run++; if (ovf_sticky !== 4'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b exp 0000", ovf_sticky); end
  endtask

  task automatic test_saturation();
    logic [3:0] ed [8];
    ed = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15, 4'd15};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_valid = 4'b1111;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h7000_0000 + 32'(c * 16 + i);
      tick();
      n_run++; if (drop_cnt !== ed[c]) begin
        n_fail++; $display("FAIL sat_drop_c%0d: got %0d exp %0d", c, drop_cnt, ed[c]);
      end
    end
    req_valid = '0;
    n_run++; if (ovf_sticky !== 4'b1111) begin n_fail++; $display("FAIL sat_ovf: got %b exp 1111", ovf_sticky); end
    repeat (5) tick();
    n_run++; if (drop_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d exp 15", drop_cnt); end
  endtask

  task automatic test_ovf_clr();
    do_reset();
    req_valid = 4'b0011;
    req_data[0*DW +: DW] = 32'hC000_0000;
    req_data[1*DW +: DW] = 32'hC000_0001;
    tick();
    req_valid = 4'b0010;
    ovf_clr = 4'b0010;
    req_data[1*DW +: DW] = 32'hC000_0011;
    tick();
    n_run++; if (ovf_sticky !== 4'b0010) begin n_fail++; $display("FAIL clr_setwins: got %b exp 0010", ovf_sticky); end
    n_run++; if (drop_cnt !== 4'd1) begin n_fail++; $display("FAIL clr_drop: got %0d exp 1", drop_cnt); end
    req_valid = '0;
    tick();
    ovf_clr = '0;
    n_run++; if (ovf_sticky !== 4'b0000) begin n_fail++; $display("FAIL clr_alone: got %b exp 0000", ovf_sticky); end
    n_run++; if (out_valid !== 1'b1 || out_data !== 32'hC000_0011) begin
      n_fail++; $display("FAIL clr_newest: got v=%0b data=%h exp v=1 data=c0000011", out_valid, out_data);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h5000_0000 + 32'(i);
    tick();
    req_valid = '0;
    tick();
    n_run++; if (out_valid !== 1'b1 || out_data !== 32'h5000_0000) begin
      n_fail++; $display("FAIL mrst_pre: got v=%0b data=%h exp v=1 data=50000000", out_valid, out_data);
    end
    rst_n = 1'b0;
    #1;
    n_run++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin
      n_fail++; $display("FAIL mrst_async: got v=%0b data=%h src=%0d exp all 0", out_valid, out_data, out_src);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_idle_c%0d: got %0b exp 0", c, out_valid); end
    end
    req_valid = 4'b1001;
    req_data[0*DW +: DW] = 32'h6000_0000;
    req_data[3*DW +: DW] = 32'h6000_0003;
    tick();
    req_valid = '0;
    tick();
    n_run++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'h6000_0000) begin
      n_fail++; $display("FAIL mrst_first: got v=%0b src=%0d data=%h exp v=1 src=0 data=60000000", out_valid, out_src, out_data);
    end
    tick();
    n_run++; if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 32'h6000_0003) begin
      n_fail++; $display("FAIL mrst_second: got v=%0b src=%0d data=%h exp v=1 src=3 data=60000003", out_valid, out_src, out_data);
    end
    n_run++; if (drop_cnt !== 4'd0) begin n_fail++; $display("FAIL mrst_drop: got %0d exp 0", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overwrite();
    test_back_to_back();
    test_saturation();
    test_ovf_clr();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ofs_fim_eth_sb_tx_arb.md
OFS_FIM_ETH_SB_TX_ARB -- requirements
Module: ofs_fim_eth_sb_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of sideband requesters (2..16).
REQ-002 Parameter DW, default 32, sideband data width per requester.
REQ-003 Parameter CW, default 16, width of the drop counter.
REQ-004 clk  input  1  single clock; all logic in this domain.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester word-valid; no backpressure exists, a word is offered for exactly one cycle.
REQ-007 req_data  input  NUM_REQ*DW  requester i data in bits [i*DW +: DW].
REQ-008 out_valid  output  1  merged sideband word valid, registered.
REQ-009 out_data  output  DW  merged sideband data, registered.
REQ-010 out_src  output  $clog2(NUM_REQ)  index of the requester owning out_data, registered.
REQ-011 ovf_sticky  output  NUM_REQ  per-requester sticky overwrite flag.
REQ-012 ovf_clr  input  NUM_REQ  per-requester clear pulse for ovf_sticky.
REQ-013 drop_cnt  output  CW  total overwritten words, saturating.

Function
REQ-014 Each requester SHALL own a one-entry holding register (pend_vld[i], pend_data[i]).
REQ-015 req_valid[i]=1 SHALL load req_data[i] into pend_data[i] and set pend_vld[i] at the next edge.
REQ-016 Each cycle, at most one requester with pend_vld=1 SHALL be granted, round-robin: search starts at last_grant+1 modulo NUM_REQ.
REQ-017 On grant of i: out_valid=1, out_data=pend_data[i], out_src=i at the next edge; last_grant<=i; pend_vld[i] cleared unless REQ-018 applies.
REQ-018 Grant of i and req_valid[i] in the same cycle: new word loaded, pend_vld[i] stays 1, no overflow counted.
REQ-019 req_valid[i]=1 while pend_vld[i]=1 and i not granted: newest word overwrites pend_data[i], ovf_sticky[i] set, drop_cnt incremented by 1.
REQ-020 Multiple same-cycle overwrites SHALL add their count (popcount) to drop_cnt in one cycle; drop_cnt saturates at all-ones, never wraps.
REQ-021 ovf_clr[i] SHALL clear ovf_sticky[i] at the next edge; simultaneous set and clear: set wins.
REQ-022 No pending requester: out_valid=0; out_data and out_src hold last values; last_grant unchanged.
REQ-023 Latency: req_valid at cycle t with no contention -> out_valid at cycle t+2.
REQ-024 Throughput: one output word per cycle when any requester is pending.
REQ-025 Fairness: a pending requester SHALL be granted within NUM_REQ cycles.
REQ-026 Words from one requester SHALL leave in arrival order; only overwritten words are lost.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear out_valid, out_data, out_src, pend_vld, pend_data, ovf_sticky, drop_cnt to 0.
REQ-028 Reset SHALL set last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-029 Words pending at reset assertion are discarded and not counted as drops; first req_valid sampled on the first edge with rst_n=1.

Verification
REQ-030 Single word: req_valid[2]=1, data 0xA5A5_0002 at cycle 0 -> out_valid=1, out_data=0xA5A5_0002, out_src=2 at cycle 2 only; drop_cnt=0.
REQ-031 Round-robin: all 4 req_valid=1 for one cycle after reset -> out_src sequence 0,1,2,3 on consecutive cycles, then out_valid=0.
REQ-032 Overwrite: req_valid[1]=1 for 5 consecutive cycles while req 0 is also pending every cycle -> ovf_sticky[1]=1, drop_cnt counts every overwrite, the last data of req 1 is delivered.
REQ-033 Grant plus reload: requester 3 alone, valid every cycle -> out_valid=1 every cycle from cycle 2, all words delivered in order, drop_cnt=0.
REQ-034 Saturation and clear: CW=4, force 20 overwrites -> drop_cnt=15. ovf_clr[1] together with a new overwrite -> ovf_sticky[1] stays 1; ovf_clr alone -> 0.
REQ-035 Mid-operation reset: rst_n low with 3 words pending -> outputs 0 immediately; after release, out_valid stays 0 until new req_valid; next grant starts at requester 0.
